// File: rtl/mold_msg_tx.sv
// MoldUDP64 message-block framer: prepends the 16-bit big-endian length to each
// payload and re-packs the stream so every output beat is fully aligned.
module mold_msg_tx #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = DATA_W / 8,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              in_valid_i,
    input  logic              in_start_i,
    input  logic [LEN_W-1:0]  in_len_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [KEEP_W-1:0] in_keep_i,
    input  logic              in_last_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [KEEP_W-1:0] out_keep_o,
    output logic              out_last_o,
    output logic [15:0]       msg_cnt_o,
    output logic              err_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BODY  = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    localparam int CNT_W = $clog2(KEEP_W + 1);

    logic [1:0]        state_q,     state_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [KEEP_W-1:0] out_keep_q,  out_keep_d;
    logic              out_last_q,  out_last_d;
    logic [15:0]       held_q,      held_d;
    logic [1:0]        held_n_q,    held_n_d;
    logic [LEN_W-1:0]  len_q,       len_d;
    logic [LEN_W:0]    byte_cnt_q,  byte_cnt_d;
    logic [15:0]       msg_cnt_q,   msg_cnt_d;
    logic              err_q,       err_d;

    logic [CNT_W-1:0]  beat_n;
    logic [CNT_W:0]    beat_n2;
    logic              spill;
    logic [15:0]       lead;
    logic [DATA_W-1:0] raw_data;
    logic [DATA_W-1:0] beat_data;
    logic [KEEP_W-1:0] beat_keep;
    logic [DATA_W-1:0] flush_data;
    logic [KEEP_W-1:0] flush_keep;
    logic [LEN_W-1:0]  len_ref;
    logic [LEN_W:0]    cnt_total;
    logic              in_acc;
    logic              take;
    logic              out_fire;

    assign in_ready_o = nreset & (state_q != FLUSH) & (~out_valid_q | out_ready_i);
    assign in_acc     = in_valid_i & in_ready_o;
    assign take       = in_acc & ((state_q == BODY) | in_start_i);
    assign out_fire   = out_valid_q & out_ready_i;

    // Output beat = two leading bytes (length on the first beat, the previous
    // beat's top two lanes afterwards) followed by the low six input lanes.
    always_comb begin
        beat_n = '0;
        for (int unsigned i = 0; i < KEEP_W; i++) begin
            beat_n = beat_n + CNT_W'(in_keep_i[i]);
        end
        beat_n2 = {1'b0, beat_n} + (CNT_W + 1)'(2);
        spill   = beat_n > CNT_W'(KEEP_W - 2);

        lead     = (state_q == IDLE) ? {in_len_i[7:0], in_len_i[15:8]} : held_q;
        raw_data = {in_data_i[DATA_W-17:0], lead};
        for (int unsigned i = 0; i < KEEP_W; i++) begin
            beat_keep[i]       = (CNT_W + 1)'(i) < beat_n2;
            beat_data[8*i +: 8] = beat_keep[i] ? raw_data[8*i +: 8] : 8'h00;
        end

        flush_keep = (held_n_q == 2'd1) ? KEEP_W'(1) : KEEP_W'(3);
        flush_data = {{(DATA_W-16){1'b0}},
                      ((held_n_q == 2'd1) ? {8'h00, held_q[7:0]} : held_q)};

        len_ref   = (state_q == IDLE) ? in_len_i : len_q;
        cnt_total = ((state_q == IDLE) ? '0 : byte_cnt_q) + (LEN_W + 1)'(beat_n);
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        held_d      = held_q;
        held_n_d    = held_n_q;
        len_d       = len_q;
        byte_cnt_d  = byte_cnt_q;
        msg_cnt_d   = msg_cnt_q;
        err_d       = 1'b0;

        if (out_fire) begin
            out_valid_d = 1'b0;
            if (out_last_q) begin
                msg_cnt_d = msg_cnt_q + 16'd1;
            end
        end

        if (take) begin
            out_valid_d = 1'b1;
            out_data_d  = beat_data;
            out_keep_d  = beat_keep;
            out_last_d  = in_last_i & ~spill;
            held_d      = in_data_i[DATA_W-1 -: 16];
            held_n_d    = spill ? 2'(beat_n - CNT_W'(KEEP_W - 2)) : 2'd0;
            len_d       = len_ref;
            byte_cnt_d  = cnt_total;
            if (in_last_i) begin
                state_d = spill ? FLUSH : IDLE;
                err_d   = cnt_total != {1'b0, len_ref};
            end else begin
                state_d = BODY;
            end
        end else if (in_acc) begin
            err_d = 1'b1;
        end

        // FLUSH: the last data beat (last=0) drains first, then the two-lane
        // tail beat (last=1) is loaded; its handshake ends the block.
        if (state_q == FLUSH) begin
            if (!out_last_q && (!out_valid_q || out_ready_i)) begin
                out_valid_d = 1'b1;
                out_data_d  = flush_data;
                out_keep_d  = flush_keep;
                out_last_d  = 1'b1;
            end else if (out_last_q && out_fire) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            held_q      <= '0;
            held_n_q    <= '0;
            len_q       <= '0;
            byte_cnt_q  <= '0;
            msg_cnt_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            held_q      <= held_d;
            held_n_q    <= held_n_d;
            len_q       <= len_d;
            byte_cnt_q  <= byte_cnt_d;
            msg_cnt_q   <= msg_cnt_d;
            err_q       <= err_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_keep_o  = out_keep_q;
    assign out_last_o  = out_last_q;
    assign msg_cnt_o   = msg_cnt_q;
    assign err_o       = err_q;

endmodule

// File: doc/mold_msg_tx.md
MOLD_MSG_TX -- requirements
Module: mold_msg_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 64, output/input bus width in bits; only 64 supported.
REQ-002 SHALL have parameter KEEP_W, default DATA_W/8, byte-enable width.
REQ-003 SHALL have parameter LEN_W, default 16, MoldUDP64 message length field width.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port nreset  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid_i  input  1  input beat valid.
REQ-007 SHALL have port in_start_i  input  1  first beat of a message.
REQ-008 SHALL have port in_len_i  input  LEN_W  message payload length in bytes, sampled on start beat only.
REQ-009 SHALL have port in_data_i  input  DATA_W  payload; lane n = bits [8n+7:8n], lane 0 first on wire.
REQ-010 SHALL have port in_keep_i  input  KEEP_W  valid lanes, contiguous from lane 0.
REQ-011 SHALL have port in_last_i  input  1  final beat of message.
REQ-012 SHALL have port in_ready_o  output  1  input beat accepted when in_valid_i & in_ready_o.
REQ-013 SHALL have ports out_valid_o output 1, out_ready_i input 1, out_data_o output DATA_W, out_keep_o output KEEP_W, out_last_o output 1: framed message-block stream, same lane convention.
REQ-014 SHALL have port msg_cnt_o  output  16  count of completed message blocks, wraps 0xFFFF->0.
REQ-015 SHALL have port err_o  output  1  one-cycle error pulse.

Function
REQ-016 SHALL emit each message as a MoldUDP64 message block: lane 0 = in_len_i[15:8], lane 1 = in_len_i[7:0], then payload bytes in order.
REQ-017 SHALL map output beat k: lanes 0-1 = previous input beat lanes 6-7 (k>0) or length (k=0); lanes 2-7 = current input beat lanes 0-5.
REQ-018 SHALL implement states IDLE, BODY, FLUSH; reset state IDLE.
REQ-019 IDLE: accepted beat with in_start_i=1 -> emit first output beat; go BODY, or IDLE if in_last_i and no flush needed, or FLUSH if in_last_i and popcount(in_keep_i)>6.
REQ-020 IDLE: accepted beat with in_start_i=0 SHALL be discarded, pulse err_o, produce no output.
REQ-021 BODY: in_start_i ignored; accepted in_last_i beat -> FLUSH if popcount(in_keep_i)>6, else IDLE.
REQ-022 FLUSH: in_ready_o=0; emit one beat with held lanes 6-7 in lanes 0-1, keep 0x01 or 0x03, out_last_o=1; return IDLE on output handshake.
REQ-023 out_last_o SHALL be 1 exactly on the final beat of a block; out_keep_o contiguous from lane 0; unused lanes of out_data_o SHALL be 0.
REQ-024 Zero-length message (start & last, keep=0x00) SHALL produce one beat, keep 0x03, last=1.
REQ-025 Output SHALL be registered: 1-cycle latency from input handshake to out_valid_o.
REQ-026 in_ready_o SHALL equal (state!=FLUSH) & (!out_valid_o | out_ready_i); no combinational path from in_valid_i to in_ready_o.
REQ-027 While out_valid_o=1 and out_ready_i=0, out_data_o/out_keep_o/out_last_o SHALL hold stable.
REQ-028 SHALL count accepted payload bytes (LEN_W+1 bits); on last beat, if count != latched length, pulse err_o one cycle after; block still emitted as received.
REQ-029 msg_cnt_o SHALL increment by 1 on each output handshake with out_last_o=1.
REQ-030 Simultaneous output handshake and new input handshake SHALL both complete in the same cycle without bubbles.

Reset
REQ-031 nreset low SHALL asynchronously force state IDLE, out_valid_o=0, out_data_o=0, out_keep_o=0, out_last_o=0, msg_cnt_o=0, err_o=0, byte count 0.
REQ-032 Reset mid-message SHALL drop the partial block; after release, first accepted start beat begins a fresh block.
REQ-033 in_ready_o SHALL be 0 while nreset is low.

Verification
REQ-034 len=4, one beat data 0x..44332211 keep 0x0F last -> one beat, lanes 00 04 11 22 33 44, keep 0x3F, last=1, msg_cnt_o=1.
REQ-035 len=8, one beat bytes 01..08 keep 0xFF last -> beat {00,08,01..06} keep 0xFF last=0, then FLUSH beat {07,08} keep 0x03 last=1; in_ready_o=0 during FLUSH.
REQ-036 len=0, start&last keep 0x00 -> one beat {00,00} keep 0x03 last=1.
REQ-037 len=10, 2 beats of 8 and 2 bytes with out_ready_i toggled 1,0,0,1 -> output held stable while stalled, 2 beats total, keep 0xFF then 0x0F, no data loss.
REQ-038 len=5 declared, 3 bytes sent -> block of 5 bytes (2 length + 3 payload) emitted, err_o pulses once; beat without start in IDLE -> discarded, err_o pulse, no output.
REQ-039 nreset asserted during BODY of 3-beat message -> outputs zero immediately; next message after release framed correctly, msg_cnt_o=1.
